regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//  Schedules the register file's single write port (rd/we/wd, written on negedge clk) between two sources.
//  - Source A: in-order pipeline WB stage, single-cycle.
//  - Source B: long-latency unit (mul/div, load miss), buffered in a small FIFO.
//  Keeps a per-register busy scoreboard for outstanding B ops and raises issue_stall for dependent decodes.
//  Sits between the WB stage / long-latency units and the register file.
// PARAMETERS
//  XLEN          32  data width of write data
//  FIFO_DEPTH    2   source-B buffer entries (power of 2, >=2)
//  STARVE_LIMIT  4   cycles B may wait at FIFO head before wb_hold is forced (>=2)
// PORTS
//  clk          in   1     clock
//  rst          in   1     asynchronous, active-low reset
//  a_valid      in   1     WB stage write request (no ready; never back-pressured except via wb_hold)
//  a_rd         in   5     WB destination register
//  a_wd         in   XLEN  WB write data
//  b_valid      in   1     long-latency result valid
//  b_ready      out  1     FIFO can accept B (= !full)
//  b_rd         in   5     B destination register
//  b_wd         in   XLEN  B write data
//  sb_set       in   1     long-latency op issued this cycle
//  sb_rd        in   5     its destination register
//  dec_rs1      in   5     decode-stage source 1
//  dec_rs2      in   5     decode-stage source 2
//  dec_rd       in   5     decode-stage destination
//  issue_stall  out  1     decode must stall (RAW/WAW on busy reg)
//  wb_hold      out  1     registered; when 1, WB must present a_valid=0 this cycle
//  rf_we        out  1     register file write enable
//  rf_rd        out  5     register file write address
//  rf_wd        out  XLEN  register file write data
//  busy         out  32    scoreboard view; bit 0 always 0
// BEHAVIOUR
//  Reset (rst=0, async): FIFO count/pointers=0; busy=0; starve_cnt=0; wb_hold=0.
//   While rst=0: b_ready=0, rf_we=0, issue_stall=0. FIFO contents are discarded on mid-operation reset.
//  FIFO: push on b_valid&&b_ready at posedge. b_ready comes from registered count.
//   No bypass: an entry pushed in cycle N is writable at earliest in N+1.
//   Simultaneous push+pop while not full: count unchanged.
//  Port select (combinational, same cycle; the RF commits at that cycle's negedge):
//   1) a_valid && a_rd!=0 -> rf_we=1, rf_rd=a_rd, rf_wd=a_wd.
//   2) else if FIFO non-empty -> pop head: rf_we=1, rf_rd/rf_wd from head.
//   3) else rf_we=0; rf_rd/rf_wd=0.
//   A with rd=0 counts as no write and frees the slot for B.
//   A B entry with rd=0 pops with rf_we=0.
//  Starvation:
//   - starve_cnt increments each cycle FIFO is non-empty and not popped; it clears on any pop or when empty.
//   - When starve_cnt==STARVE_LIMIT-1 with no pop, wb_hold<=1 for exactly one cycle.
//   - In the wb_hold cycle, B pops.
//   - a_valid during wb_hold is a protocol error: A still wins (sim assertion fires) and starve_cnt keeps counting.
//  Scoreboard:
//   - sb_set with sb_rd!=0 sets busy[sb_rd] at posedge.
//   - A B pop with rd!=0 clears busy[rd] at posedge.
//   - Same register set and cleared in one cycle: set wins.
//   - A writes never touch busy.
//  issue_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd].
//   Registered busy, so the stall drops the cycle after the commit, when the RF read already returns new data.
// STRUCTURE
//  Shared package rv_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0.
//  Sub-module wb_fifo: sync FIFO, FIFO_DEPTH x (5+XLEN), with full/empty/count. Scheduler, starvation and scoreboard stay inline.
// TESTING
//  1. rst=0 mid-traffic, FIFO holding 1 entry -> b_ready=0, rf_we=0, busy=0, wb_hold=0; after release, FIFO empty.
//  2. sb_set rd=5; dec_rs1=5 -> issue_stall=1.
//     Push B rd=5 wd=32'hDEADBEEF in cycle N, a_valid=0 -> cycle N+1: rf_we=1, rf_rd=5, rf_wd=DEADBEEF.
//     Cycle N+2: busy[5]=0, issue_stall=0.
//  3. a_valid=1 rd=3 every cycle; B push rd=7 -> rf_rd=3 for 4 cycles, then wb_hold=1.
//     Bench drops a_valid -> rf_rd=7 that cycle; wb_hold=0 next cycle.
//  4. A saturating and 2 B pushes -> b_ready=0; a third b_valid is held until the first pop.
//  5. a_valid=1 a_rd=0 with B rd=12 pending -> rf_rd=12 same cycle. sb_set rd=0 -> busy stays 0.
//  6. B commits rd=9 in the same cycle as sb_set rd=9 -> busy[9]=1 after the edge; dec_rs2=9 keeps issue_stall=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file definitions for the writeback scheduler slice.
// Holds the data width, register addressing constants, the writeback source
// encoding and a helper that decides whether a destination really writes.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Which source owns the register file write port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } wb_src_e;

  // x0 is hardwired, so a write to it is architecturally a no-op.
  function automatic logic is_real_dest(input reg_addr_t rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Bundle of all scheduler-facing signals.
//   master : WB stage, long-latency units, decode and the register file side
//   slave  : the writeback scheduler itself
// Inputs to the scheduler: a_* (WB stage), b_* (long-latency result),
// sb_* (long-latency issue), dec_* (decode operands).
// Outputs: b_ready, issue_stall, wb_hold, rf_we/rf_rd/rf_wd, busy.
interface regfile_wb_sched_if #(
  parameter int XLEN = rv_pkg::XLEN
);
  import rv_pkg::*;

  logic                a_valid;
  reg_addr_t           a_rd;
  logic [XLEN-1:0]     a_wd;
  logic                b_valid;
  logic                b_ready;
  reg_addr_t           b_rd;
  logic [XLEN-1:0]     b_wd;
  logic                sb_set;
  reg_addr_t           sb_rd;
  reg_addr_t           dec_rs1;
  reg_addr_t           dec_rs2;
  reg_addr_t           dec_rd;
  logic                issue_stall;
  logic                wb_hold;
  logic                rf_we;
  reg_addr_t           rf_rd;
  logic [XLEN-1:0]     rf_wd;
  logic [NUM_REGS-1:0] busy;

  modport master (
    output a_valid, a_rd, a_wd,
    output b_valid, b_rd, b_wd,
    output sb_set, sb_rd,
    output dec_rs1, dec_rs2, dec_rd,
    input  b_ready, issue_stall, wb_hold,
    input  rf_we, rf_rd, rf_wd, busy
  );

  modport slave (
    input  a_valid, a_rd, a_wd,
    input  b_valid, b_rd, b_wd,
    input  sb_set, sb_rd,
    input  dec_rs1, dec_rs2, dec_rd,
    output b_ready, issue_stall, wb_hold,
    output rf_we, rf_rd, rf_wd, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency writeback results.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head, no
// bypass), full, empty, count. Push while full and pop while empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is data-only; stale contents are harmless once pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register file write-port scheduler.
// Arbitrates the single RF write port between the in-order WB stage (source A,
// always preferred) and buffered long-latency results (source B), forces a
// one-cycle wb_hold when a B result has waited too long, and keeps a busy
// scoreboard of registers with outstanding long-latency writes.
// Ports: clk, rst_n (async active-low), bus (regfile_wb_sched_if.slave).
module regfile_wb_sched #(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_sched_if.slave     bus
);
  import rv_pkg::*;

  localparam int ENTRY_W  = REG_ADDR_W + XLEN;
  localparam int CNT_W    = $clog2(FIFO_DEPTH+1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

  wb_src_e              src;
  logic                 b_ready;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENTRY_W-1:0]   head;
  reg_addr_t            head_rd;
  logic [XLEN-1:0]      head_wd;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 wb_hold;
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_next;

  // b_ready is derived from the registered FIFO count only, never from pops.
  assign b_ready = rst_n && !full;
  assign push    = bus.b_valid && b_ready;
  assign head_rd = head[ENTRY_W-1 -: REG_ADDR_W];
  assign head_wd = head[XLEN-1:0];

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({bus.b_rd, bus.b_wd}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // A write to x0 from the WB stage leaves the port free for a B pop.
  always_comb begin
    src = SRC_NONE;
    if (bus.a_valid && is_real_dest(bus.a_rd)) begin
      src = SRC_A;
    end else if (!empty) begin
      src = SRC_B;
    end
  end

  assign pop = (src == SRC_B);

  // A popped B entry targeting x0 is drained without asserting the write.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_rd = REG_ZERO;
    bus.rf_wd = '0;
    case (src)
      SRC_A: begin
        bus.rf_we = 1'b1;
        bus.rf_rd = bus.a_rd;
        bus.rf_wd = bus.a_wd;
      end
      SRC_B: begin
        bus.rf_we = is_real_dest(head_rd);
        bus.rf_rd = head_rd;
        bus.rf_wd = head_wd;
      end
      default: ;
    endcase
    if (!rst_n) begin
      bus.rf_we = 1'b0;
    end
  end

  // Starvation tracking: the counter measures how long the head has waited.
  // Hold is raised on the single cycle the count hits LIMIT-1 without a pop;
  // if the WB stage ignores it the count runs on, so the hold stays one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end else begin
      wb_hold <= !empty && !pop && (starve_cnt == STARVE_W'(STARVE_LIMIT-1));
      if (pop || empty) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  // Scoreboard update: clear on B commit first, then set so a new issue to
  // the same register in that cycle keeps it busy.
  always_comb begin
    busy_next = busy_q;
    if (pop && is_real_dest(head_rd)) begin
      busy_next[head_rd] = 1'b0;
    end
    if (bus.sb_set && is_real_dest(bus.sb_rd)) begin
      busy_next[bus.sb_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign bus.b_ready     = b_ready;
  assign bus.wb_hold     = wb_hold;
  assign bus.busy        = busy_q;
  assign bus.issue_stall = busy_q[bus.dec_rs1] | busy_q[bus.dec_rs2] | busy_q[bus.dec_rd];

  a_valid_during_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_hold && bus.a_valid));

  fifo_count_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (empty == (fifo_count == '0)) && (full == (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios checked
// against fixed expectations, then randomized traffic checked against a
// queue-based behavioural model of the scheduler.
module tb_regfile_wb_sched;
  import rv_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_wb_sched_if #(.XLEN(XLEN)) bus ();

  regfile_wb_sched #(
    .XLEN         (XLEN),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model state
  ent_t        q[$];
  logic [31:0] m_busy;
  int          m_wait;
  bit          m_hold;
  logic        e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  logic        e_ready;
  logic        e_stall;

  function automatic void model_eval();
    bit a_wr;
    a_wr    = bus.a_valid && (bus.a_rd != 5'd0);
    e_ready = (q.size() < DEPTH);
    e_stall = m_busy[bus.dec_rs1] | m_busy[bus.dec_rs2] | m_busy[bus.dec_rd];
    e_we = 1'b0;
    e_rd = 5'd0;
    e_wd = 32'd0;
    if (a_wr) begin
      e_we = 1'b1;
      e_rd = bus.a_rd;
      e_wd = bus.a_wd;
    end else if (q.size() > 0) begin
      e_we = (q[0].rd != 5'd0);
      e_rd = q[0].rd;
      e_wd = q[0].wd;
    end
  endfunction

  function automatic void model_update();
    bit   a_wr;
    bit   popped;
    bit   was_full;
    bit   next_hold;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_busy = 32'd0;
      m_wait = 0;
      m_hold = 1'b0;
      return;
    end
    a_wr      = bus.a_valid && (bus.a_rd != 5'd0);
    popped    = !a_wr && (q.size() > 0);
    was_full  = (q.size() >= DEPTH);
    next_hold = (q.size() > 0) && !popped && (m_wait == LIMIT - 1);
    if (popped || q.size() == 0) m_wait = 0;
    else m_wait = m_wait + 1;
    if (popped) begin
      e = q.pop_front();
      if (e.rd != 5'd0) m_busy[e.rd] = 1'b0;
    end
    if (bus.b_valid && !was_full) begin
      e.rd = bus.b_rd;
      e.wd = bus.b_wd;
      q.push_back(e);
    end
    if (bus.sb_set && bus.sb_rd != 5'd0) m_busy[bus.sb_rd] = 1'b1;
    m_hold = next_hold;
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
    bus.a_rd    = 5'd0;
    bus.a_wd    = 32'd0;
    bus.b_valid = 1'b0;
    bus.b_rd    = 5'd0;
    bus.b_wd    = 32'd0;
    bus.sb_set  = 1'b0;
    bus.sb_rd   = 5'd0;
    bus.dec_rs1 = 5'd0;
    bus.dec_rs2 = 5'd0;
    bus.dec_rd  = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd3;
    #2;
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_rf_we: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_b_ready: got %0b expected 0", bus.b_ready); end
    checks++; if (bus.wb_hold !== 1'b0) begin failures++; $display("[TB] FAIL rst_wb_hold: got %0b expected 0", bus.wb_hold); end
    checks++; if (bus.busy !== 32'd0) begin failures++; $display("[TB] FAIL rst_busy: got %0h expected 0", bus.busy); end
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    #2;
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_b_ready: got %0b expected 1", bus.b_ready); end
    tick();

    // Reset in the middle of traffic with one buffered entry.
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_wd = 32'h1111;
    bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_wd = 32'h4444;
    bus.sb_set  = 1'b1; bus.sb_rd = 5'd4;
    tick();
    bus.b_valid = 1'b0; bus.sb_set = 1'b0; bus.dec_rs1 = 5'd4;
    #2;
    checks++; if (bus.issue_stall !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_stall: got %0b expected 1", bus.issue_stall); end
    rst_n = 1'b0;
    #2;
    checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_b_ready: got %0b expected 0", bus.b_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_rf_we: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.busy !== 32'd0) begin failures++; $display("[TB] FAIL mid_rst_busy: got %0h expected 0", bus.busy); end
    checks++; if (bus.issue_stall !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_stall: got %0b expected 0", bus.issue_stall); end
    checks++; if (bus.wb_hold !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_wb_hold: got %0b expected 0", bus.wb_hold); end
    tick();
    rst_n = 1'b1;
    idle();
    #2;
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_fifo_empty: got rf_we=%0b expected 0", bus.rf_we); end
    tick();
  endtask

  task automatic test_scoreboard_commit();
    idle();
    bus.sb_set = 1'b1; bus.sb_rd = 5'd5;
    tick();
    bus.sb_set = 1'b0; bus.dec_rs1 = 5'd5;
    bus.b_valid = 1'b1; bus.b_rd = 5'd5; bus.b_wd = 32'hDEADBEEF;
    #2;
    checks++; if (bus.issue_stall !== 1'b1) begin failures++; $display("[TB] FAIL sb_stall: got %0b expected 1", bus.issue_stall); end
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL sb_no_bypass: got %0b expected 0", bus.rf_we); end
    tick();
    bus.b_valid = 1'b0;
    #2;
    checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("[TB] FAIL sb_commit_we: got %0b expected 1", bus.rf_we); end
    checks++; if (bus.rf_rd !== 5'd5) begin failures++; $display("[TB] FAIL sb_commit_rd: got %0d expected 5", bus.rf_rd); end
    checks++; if (bus.rf_wd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL sb_commit_wd: got %0h expected deadbeef", bus.rf_wd); end
    tick();
    #2;
    checks++; if (bus.busy[5] !== 1'b0) begin failures++; $display("[TB] FAIL sb_busy_clear: got %0b expected 0", bus.busy[5]); end
    checks++; if (bus.issue_stall !== 1'b0) begin failures++; $display("[TB] FAIL sb_stall_drop: got %0b expected 0", bus.issue_stall); end
    tick();
  endtask

  task automatic test_starvation();
    logic [31:0] w;
    idle();
    w = $urandom();
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_wd = $urandom();
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_wd = w;
    #2;
    checks++; if (bus.rf_rd !== 5'd3) begin failures++; $display("[TB] FAIL starve_push_rd: got %0d expected 3", bus.rf_rd); end
    tick();
    bus.b_valid = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      bus.a_wd = $urandom();
      #2;
      checks++; if (bus.rf_rd !== 5'd3) begin failures++; $display("[TB] FAIL starve_a_wins k=%0d: got %0d expected 3", k, bus.rf_rd); end
      checks++; if (bus.wb_hold !== 1'b0) begin failures++; $display("[TB] FAIL starve_early_hold k=%0d: got %0b expected 0", k, bus.wb_hold); end
      tick();
    end
    #2;
    checks++; if (bus.wb_hold !== 1'b1) begin failures++; $display("[TB] FAIL starve_hold: got %0b expected 1", bus.wb_hold); end
    bus.a_valid = 1'b0;
    #2;
    checks++; if (bus.rf_rd !== 5'd7 || bus.rf_we !== 1'b1) begin failures++; $display("[TB] FAIL starve_b_pop: got rd=%0d we=%0b expected rd=7 we=1", bus.rf_rd, bus.rf_we); end
    checks++; if (bus.rf_wd !== w) begin failures++; $display("[TB] FAIL starve_b_wd: got %0h expected %0h", bus.rf_wd, w); end
    tick();
    #2;
    checks++; if (bus.wb_hold !== 1'b0) begin failures++; $display("[TB] FAIL starve_hold_once: got %0b expected 0", bus.wb_hold); end
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_wd = 32'h33;
    bus.b_valid = 1'b1; bus.b_rd = 5'd10; bus.b_wd = 32'hA0;
    tick();
    bus.b_rd = 5'd11; bus.b_wd = 32'hB0;
    #2;
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_ready: got %0b expected 1", bus.b_ready); end
    tick();
    bus.b_rd = 5'd13; bus.b_wd = 32'hD0;
    for (int c = 2; c <= 4; c++) begin
      #2;
      checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full c=%0d: got %0b expected 0", c, bus.b_ready); end
      tick();
    end
    #2;
    checks++; if (bus.wb_hold !== 1'b1 || bus.b_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold: got hold=%0b ready=%0b expected hold=1 ready=0", bus.wb_hold, bus.b_ready); end
    bus.a_valid = 1'b0;
    #2;
    checks++; if (bus.rf_rd !== 5'd10) begin failures++; $display("[TB] FAIL bp_pop1: got %0d expected 10", bus.rf_rd); end
    tick();
    #2;
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_after_pop: got %0b expected 1", bus.b_ready); end
    checks++; if (bus.rf_rd !== 5'd11) begin failures++; $display("[TB] FAIL bp_pop2: got %0d expected 11", bus.rf_rd); end
    tick();
    bus.b_valid = 1'b0;
    #2;
    checks++; if (bus.rf_rd !== 5'd13 || bus.rf_wd !== 32'hD0) begin failures++; $display("[TB] FAIL bp_pop3: got rd=%0d wd=%0h expected rd=13 wd=d0", bus.rf_rd, bus.rf_wd); end
    tick();
    #2;
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained: got %0b expected 0", bus.rf_we); end
    tick();
  endtask

  task automatic test_rd_zero();
    idle();
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_wd = 32'h3;
    bus.b_valid = 1'b1; bus.b_rd = 5'd12; bus.b_wd = 32'hC12;
    tick();
    bus.b_valid = 1'b0;
    bus.a_rd = 5'd0; bus.a_wd = 32'hFFFF;
    bus.sb_set = 1'b1; bus.sb_rd = 5'd0;
    #2;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd12) begin failures++; $display("[TB] FAIL a_x0_b_pops: got we=%0b rd=%0d expected we=1 rd=12", bus.rf_we, bus.rf_rd); end
    checks++; if (bus.rf_wd !== 32'hC12) begin failures++; $display("[TB] FAIL a_x0_b_wd: got %0h expected c12", bus.rf_wd); end
    tick();
    idle();
    #2;
    checks++; if (bus.busy !== 32'd0) begin failures++; $display("[TB] FAIL sb_x0_busy: got %0h expected 0", bus.busy); end
    tick();
  endtask

  task automatic test_set_wins();
    idle();
    bus.sb_set = 1'b1; bus.sb_rd = 5'd9;
    bus.a_valid = 1'b1; bus.a_rd = 5'd3;
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_wd = 32'h99;
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.dec_rs2 = 5'd9;
    #2;
    checks++; if (bus.rf_rd !== 5'd9 || bus.rf_we !== 1'b1) begin failures++; $display("[TB] FAIL setwin_commit: got rd=%0d we=%0b expected rd=9 we=1", bus.rf_rd, bus.rf_we); end
    tick();
    bus.sb_set = 1'b0;
    #2;
    checks++; if (bus.busy[9] !== 1'b1) begin failures++; $display("[TB] FAIL setwin_busy: got %0b expected 1", bus.busy[9]); end
    checks++; if (bus.issue_stall !== 1'b1) begin failures++; $display("[TB] FAIL setwin_stall: got %0b expected 1", bus.issue_stall); end
    tick();
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus.a_valid = m_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.a_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.a_wd    = $urandom();
      bus.b_valid = $urandom_range(0, 1) == 1;
      bus.b_rd    = 5'($urandom_range(0, 15));
      bus.b_wd    = $urandom();
      bus.sb_set  = $urandom_range(0, 2) == 0;
      bus.sb_rd   = 5'($urandom_range(0, 15));
      bus.dec_rs1 = 5'($urandom_range(0, 15));
      bus.dec_rs2 = 5'($urandom_range(0, 15));
      bus.dec_rd  = 5'($urandom_range(0, 15));
      model_eval();
      #2;
      checks++; if (bus.rf_we !== e_we) begin failures++; $display("[TB] FAIL rnd_rf_we i=%0d: got %0b expected %0b", i, bus.rf_we, e_we); end
      checks++; if (bus.rf_rd !== e_rd) begin failures++; $display("[TB] FAIL rnd_rf_rd i=%0d: got %0d expected %0d", i, bus.rf_rd, e_rd); end
      checks++; if (bus.rf_wd !== e_wd) begin failures++; $display("[TB] FAIL rnd_rf_wd i=%0d: got %0h expected %0h", i, bus.rf_wd, e_wd); end
      checks++; if (bus.b_ready !== e_ready) begin failures++; $display("[TB] FAIL rnd_b_ready i=%0d: got %0b expected %0b", i, bus.b_ready, e_ready); end
      checks++; if (bus.wb_hold !== m_hold) begin failures++; $display("[TB] FAIL rnd_wb_hold i=%0d: got %0b expected %0b", i, bus.wb_hold, m_hold); end
      checks++; if (bus.busy !== m_busy) begin failures++; $display("[TB] FAIL rnd_busy i=%0d: got %0h expected %0h", i, bus.busy, m_busy); end
      checks++; if (bus.issue_stall !== e_stall) begin failures++; $display("[TB] FAIL rnd_stall i=%0d: got %0b expected %0b", i, bus.issue_stall, e_stall); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    q.delete();
    m_busy = 32'd0;
    m_wait = 0;
    m_hold = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_scoreboard_commit();
    test_starvation();
    test_backpressure();
    test_rd_zero();
    test_set_wins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
